// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default oversampling factor and
// the mid-bit / end-bit tick positions used by both receive and transmit paths.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_e;

   localparam int OSF_DEFAULT      = 16;
   localparam int MID_TICK_DEFAULT = OSF_DEFAULT / 2 - 1;
   localparam int END_TICK_DEFAULT = OSF_DEFAULT - 1;

   // Tick index at the centre of the start bit, measured from the falling edge.
   function automatic int mid_tick(input int osf);
      return osf / 2 - 1;
   endfunction

   // Tick index one full bit period after the previous sample point.
   function automatic int end_tick(input int osf);
      return osf - 1;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; 2 clk latency.
// RESET_VAL sets the value both flops take during reset (idle level of the line).
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS LSB-first, optional parity, 1 stop; one-clk rx_done strobe.
// Parity bit and parity_error logic exist only when UART_RX_PARITY_EN is defined.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS           = 8,
   parameter int OVERSAMPLING_FACTOR = OSF_DEFAULT,
   parameter int PARITY_ODD          = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 rx_busy,
   output logic                 frame_error,
   output logic                 parity_error
);

   localparam int             TW       = $clog2(OVERSAMPLING_FACTOR);
   localparam int             BW       = $clog2(DATA_BITS);
   localparam logic [TW-1:0]  MID_TICK = TW'(mid_tick(OVERSAMPLING_FACTOR));
   localparam logic [TW-1:0]  END_TICK = TW'(end_tick(OVERSAMPLING_FACTOR));
   localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_rx: unsupported DATA_BITS or PARITY_ODD");
   end

   logic                 rx_s;
   uart_state_e          state_q;
   logic [TW-1:0]        tick_cnt_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_done_q;
   logic                 busy_q;
   logic                 frame_error_q;

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (rx),
      .q_o (rx_s)
   );

   // Line order is LSB first, so each new bit enters at the top and slides down.
   assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = PARITY_ODD[0];
   logic par_bad_q;
   logic par_bad_d;
   logic parity_error_q;

   assign par_bad_d = ^shift_q ^ rx_s ^ PAR_ODD;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         tick_cnt_q     <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         rx_data_q      <= '0;
         rx_done_q      <= 1'b0;
         busy_q         <= 1'b0;
         frame_error_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q      <= 1'b0;
         parity_error_q <= 1'b0;
`endif
      end else begin
         rx_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               tick_cnt_q <= '0;
               if (!rx_s) begin
                  state_q <= S_START;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (sample_tick) begin
                  if (tick_cnt_q == MID_TICK) begin
                     tick_cnt_q <= '0;
                     if (!rx_s) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                     end else begin
                        // Start bit gone by mid-bit: a glitch, not a frame.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (sample_tick) begin
                  if (tick_cnt_q == END_TICK) begin
                     tick_cnt_q <= '0;
                     shift_q    <= shift_d;
                     if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= S_PARITY;
`else
                        state_q <= S_STOP;
`endif
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (sample_tick) begin
                  if (tick_cnt_q == END_TICK) begin
                     tick_cnt_q <= '0;
                     par_bad_q  <= par_bad_d;
                     state_q    <= S_STOP;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
`endif
            S_STOP: begin
               if (sample_tick) begin
                  if (tick_cnt_q == END_TICK) begin
                     tick_cnt_q     <= '0;
                     rx_data_q      <= shift_q;
                     frame_error_q  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                     parity_error_q <= par_bad_q;
`endif
                     rx_done_q      <= 1'b1;
                     busy_q         <= 1'b0;
                     state_q        <= S_IDLE;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_done     = rx_done_q;
   assign rx_busy     = busy_q;
   assign frame_error = frame_error_q;
`ifdef UART_RX_PARITY_EN
   assign parity_error = parity_error_q;
`else
   assign parity_error = 1'b0;
`endif

endmodule
